output_layer: RTL and testbench
===============================

// Module: output_layer
// PURPOSE
//  Downstream stage of the 4-neuron hidden layer. Captures the four 12-bit signed hidden
//  outputs when the hidden layer's ready pulse arrives, then applies ReLU and requantizes
//  each one to a 5-bit activation. It computes two output neurons with one time-shared
//  5x5 multiplier over 8 MAC cycles, then drives registered results plus a 1-cycle ready pulse.
// PARAMETERS
//  SHIFT   4   arithmetic right shift applied after ReLU (requantization, 12b -> 5b)
//  ACT_MAX 15  activation clamp ceiling (unsigned activation range 0..ACT_MAX, max 15)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  input_ready  in   1   1-cycle pulse: in0..in3 are valid this cycle
//  in0..in3     in   12  signed hidden-layer results
//  w04,w14,w24,w34 in 5  signed static weights, hidden j -> output neuron 0 (wj4)
//  w05,w15,w25,w35 in 5  signed static weights, hidden j -> output neuron 1 (wj5)
//  out0,out1    out  12  signed output-neuron sums, registered
//  output_ready out  1   1-cycle pulse: out0/out1 updated this cycle
//  busy         out  1   high while a computation is in flight (state != IDLE)
//  class_idx    out  1   only with OUT_LAYER_ARGMAX_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; idx, acc, act[0..3] = 0; out0=out1=0;
//   output_ready=0; busy=0; class_idx=0. A reset mid-operation aborts it and drops the result.
//  FSM: IDLE -> MAC -> DONE -> IDLE.
//   IDLE: when input_ready=1 on an edge, latch act[j] = min(ACT_MAX, max(0,in_j) >>> SHIFT).
//    Same edge sets idx=0, acc=0, state=MAC.
//   MAC: idx 0..7; neuron n = idx[2], term k = idx[1:0].
//    prod = act[k] (as 5b signed, sign 0) * w_k(4+n), a 10b signed product.
//    When k<3: acc <= acc + prod.
//    When k==3: out_n <= acc + prod and acc <= 0.
//    idx==7 -> state=DONE.
//   DONE: output_ready=1 (decoded from state) for exactly 1 cycle, then IDLE.
//  Latency: output_ready is high in the cycle after the 9th edge counted from the capture
//   edge (capture edge + 8 MAC edges).
//  out0 updates at MAC edge idx=3; out1 updates at idx=7. Both are stable from the DONE
//   cycle until the next DONE, and consumers sample them only on output_ready.
//  Widths: acc and out are 12b signed. The worst-case |sum| is 4*15*16 = 960, so no
//   overflow and no saturation logic is needed.
//  Weights are sampled live during MAC cycles and must stay static for the whole computation.
//  input_ready during MAC or DONE is ignored: it is not queued and no state is disturbed.
//  input_ready in the same cycle as DONE is also ignored; it is accepted from IDLE only.
//  busy = (state != IDLE).
// CONFIGURATION
//  OUT_LAYER_ARGMAX_EN defined:
//   Adds the class_idx output port, registered at the DONE transition.
//   class_idx = 1 if out1 > out0 (signed compare), else 0; a tie gives 0.
//   Valid whenever output_ready=1 and held until the next DONE.
//  OUT_LAYER_ARGMAX_EN undefined: the class_idx port and its logic do not exist.
//   All other behaviour is identical.
// TESTING
//  1 Basic: SHIFT=4; in0..3=64 (act 4); all w=1. Pulse input_ready.
//    -> out0=out1=16, output_ready 1 cycle, 9 edges after capture.
//  2 ReLU/clamp: in0=-500, in1=2047, in2=15, in3=255; w?4=-16, w?5=15.
//    -> acts 0,15,0,15; out0=-480, out1=450.
//  3 Worst case: in0..3=2047; all w=-16 -> out0=out1=-960; no wrap.
//  4 Busy drop: second input_ready 3 cycles after the first, with different data.
//    -> exactly one output_ready; outputs reflect the first data; busy high for 9 cycles.
//  5 Reset mid-op: assert rst_n=0 at MAC idx=5.
//    -> out0=out1=0, output_ready never pulses; a fresh input then completes normally.
//  6 ARGMAX_EN: out0=16, out1=16 -> class_idx=0; out0=-5, out1=3 -> class_idx=1,
//    valid with output_ready.

Source files
------------

// File: rtl/output_layer.sv
// Output layer: ReLU/requantizes four hidden results and computes two output neurons with one shared 5x5 multiplier.
// Optional argmax output class_idx is enabled by defining OUT_LAYER_ARGMAX_EN.
module output_layer #(
    parameter int SHIFT   = 4,
    parameter int ACT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               input_ready,
    input  logic signed [11:0] in0,
    input  logic signed [11:0] in1,
    input  logic signed [11:0] in2,
    input  logic signed [11:0] in3,
    input  logic signed [4:0]  w04,
    input  logic signed [4:0]  w14,
    input  logic signed [4:0]  w24,
    input  logic signed [4:0]  w34,
    input  logic signed [4:0]  w05,
    input  logic signed [4:0]  w15,
    input  logic signed [4:0]  w25,
    input  logic signed [4:0]  w35,
    output logic signed [11:0] out0,
    output logic signed [11:0] out1,
    output logic               output_ready,
    output logic               busy
`ifdef OUT_LAYER_ARGMAX_EN
    ,
    output logic               class_idx
`endif
);

    // state | meaning
    // IDLE  | waiting for input_ready; activations latched on acceptance
    // MAC   | idx 0..7: neuron idx[2], term idx[1:0]; out_n written at term 3
    // DONE  | output_ready high for one cycle, results stable
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [11:0] ACT_MAX_W = 12'(ACT_MAX);
    localparam logic [4:0]  ACT_MAX_A = 5'(ACT_MAX);

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         idx;
    logic signed [11:0] acc;
    logic [4:0]         act [4];

    logic [1:0]         k;
    logic               n;
    logic signed [4:0]  act_sel;
    logic signed [4:0]  w_sel;
    logic signed [9:0]  prod;
    logic signed [11:0] sum;

    // Negative inputs floor to zero; positives shift down and clamp to ACT_MAX.
    function automatic logic [4:0] requant(input logic signed [11:0] x);
        logic [11:0] s;
        if (x[11]) begin
            s = '0;
        end else begin
            s = $unsigned(x) >> SHIFT;
        end
        if (s > ACT_MAX_W) begin
            return ACT_MAX_A;
        end
        return s[4:0];
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (input_ready) state_nxt = S_MAC;
            S_MAC:   if (idx == 3'd7) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign k = idx[1:0];
    assign n = idx[2];

    always_comb begin
        w_sel = '0;
        case ({n, k})
            3'd0: w_sel = w04;
            3'd1: w_sel = w14;
            3'd2: w_sel = w24;
            3'd3: w_sel = w34;
            3'd4: w_sel = w05;
            3'd5: w_sel = w15;
            3'd6: w_sel = w25;
            3'd7: w_sel = w35;
            default: w_sel = '0;
        endcase
    end

    // Activations never exceed 15, so bit 4 is always 0 and the signed view is exact.
    assign act_sel = $signed(act[k]);
    assign prod    = act_sel * w_sel;
    assign sum     = acc + {{2{prod[9]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            acc   <= '0;
            act   <= '{default: '0};
            out0  <= '0;
            out1  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (input_ready) begin
                        act[0] <= requant(in0);
                        act[1] <= requant(in1);
                        act[2] <= requant(in2);
                        act[3] <= requant(in3);
                        idx    <= '0;
                        acc    <= '0;
                    end
                end
                S_MAC: begin
                    idx <= idx + 3'd1;
                    if (k == 2'd3) begin
                        acc <= '0;
                        if (n) begin
                            out1 <= sum;
                        end else begin
                            out0 <= sum;
                        end
                    end else begin
                        acc <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OUT_LAYER_ARGMAX_EN
    // out1 is being written on this same edge, so compare against its incoming value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_idx <= 1'b0;
        end else if (state == S_MAC && idx == 3'd7) begin
            class_idx <= (sum > out0);
        end
    end
`endif

    assign output_ready = (state == S_DONE);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_output_layer.sv
// Testbench for output_layer: directed cases plus randomized transactions against an arithmetic model.
module tb_output_layer;
    localparam int SHIFT   = 4;
    localparam int ACT_MAX = 15;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               input_ready = 1'b0;
    logic signed [11:0] in_v [4];
    logic signed [4:0]  wa [4];
    logic signed [4:0]  wb [4];
    logic signed [11:0] out0, out1;
    logic               output_ready, busy;
`ifdef OUT_LAYER_ARGMAX_EN
    logic               class_idx;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_layer #(.SHIFT(SHIFT), .ACT_MAX(ACT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .input_ready(input_ready),
        .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
        .w04(wa[0]), .w14(wa[1]), .w24(wa[2]), .w34(wa[3]),
        .w05(wb[0]), .w15(wb[1]), .w25(wb[2]), .w35(wb[3]),
        .out0(out0), .out1(out1), .output_ready(output_ready), .busy(busy)
`ifdef OUT_LAYER_ARGMAX_EN
        , .class_idx(class_idx)
`endif
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int act_of(input int x);
        int a;
        if (x < 0) return 0;
        a = x / (1 << SHIFT);
        return (a > ACT_MAX) ? ACT_MAX : a;
    endfunction

    function automatic int model_out(input int nrn);
        int s = 0;
        for (int j = 0; j < 4; j++) begin
            s += act_of(int'(in_v[j])) * ((nrn == 1) ? int'(wb[j]) : int'(wa[j]));
        end
        return s;
    endfunction

    // Launches one transaction and watches 14 samples (negedges) after the capture edge.
    // second_at > 0 injects a second, differently-valued input_ready pulse mid-computation.
    task automatic run_txn(input string tag, input int second_at);
        int e0, e1, lat, pulses, busy_cnt;
        logic signed [31:0] got0, got1, got_cls;
        e0 = model_out(0);
        e1 = model_out(1);
        lat = 0; pulses = 0; busy_cnt = 0;
        got0 = 'x; got1 = 'x; got_cls = 'x;
        @(negedge clk);
        input_ready = 1'b1;
        @(negedge clk);
        input_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            if (i > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (output_ready) begin
                pulses++;
                if (lat == 0) begin
                    lat  = i;
                    got0 = out0;
                    got1 = out1;
`ifdef OUT_LAYER_ARGMAX_EN
                    got_cls = {31'd0, class_idx};
`endif
                end
            end
            if (second_at > 0 && i == second_at) begin
                input_ready = 1'b1;
                for (int j = 0; j < 4; j++) in_v[j] = 12'sd1000 - 12'(j * 300);
            end
            if (second_at > 0 && i == second_at + 1) input_ready = 1'b0;
        end
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, 9);
        chk({tag, "_out0"}, got0, e0);
        chk({tag, "_out1"}, got1, e1);
`ifdef OUT_LAYER_ARGMAX_EN
        chk({tag, "_class_idx"}, got_cls, (e1 > e0) ? 1 : 0);
`endif
    endtask

    initial begin
        int pulses;
        for (int j = 0; j < 4; j++) begin
            in_v[j] = '0; wa[j] = '0; wb[j] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out0", out0, 0);
        chk("rst_out1", out1, 0);
        chk("rst_ready", output_ready, 0);
        chk("rst_busy", busy, 0);
`ifdef OUT_LAYER_ARGMAX_EN
        chk("rst_class_idx", class_idx, 0);
`endif
        rst_n = 1'b1;

        for (int j = 0; j < 4; j++) begin
            in_v[j] = 12'sd64; wa[j] = 5'sd1; wb[j] = 5'sd1;
        end
        run_txn("basic", 0);
        chk("basic_out0_const", out0, 16);

        in_v[0] = -12'sd500; in_v[1] = 12'sd2047; in_v[2] = 12'sd15; in_v[3] = 12'sd255;
        for (int j = 0; j < 4; j++) begin
            wa[j] = -5'sd16; wb[j] = 5'sd15;
        end
        run_txn("relu_clamp", 0);
        chk("relu_out0_const", out0, -480);
        chk("relu_out1_const", out1, 450);

        for (int j = 0; j < 4; j++) begin
            in_v[j] = 12'sd2047; wa[j] = -5'sd16; wb[j] = -5'sd16;
        end
        run_txn("worst", 0);
        chk("worst_out1_const", out1, -960);

        for (int j = 0; j < 4; j++) begin
            in_v[j] = 12'sd100 + 12'(j * 40); wa[j] = 5'(j + 1); wb[j] = -5'(j + 2);
        end
        run_txn("busy_drop", 3);

        for (int j = 0; j < 4; j++) begin
            in_v[j] = 12'sd200; wa[j] = 5'sd3; wb[j] = 5'sd2;
        end
        @(negedge clk);
        input_ready = 1'b1;
        @(negedge clk);
        input_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("midop_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midop_out0", out0, 0);
        chk("midop_out1", out1, 0);
        chk("midop_busy", busy, 0);
        chk("midop_ready", output_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (output_ready) pulses++;
        end
        chk("midop_no_pulse", pulses, 0);
        run_txn("after_reset", 0);

        for (int j = 0; j < 4; j++) begin
            in_v[j] = '0; wa[j] = '0; wb[j] = '0;
        end
        in_v[0] = 12'sd16; wa[0] = -5'sd5; wb[0] = 5'sd3;
        run_txn("argmax_pos", 0);
        chk("argmax_out0_const", out0, -5);

        for (int t = 0; t < 20; t++) begin
            for (int j = 0; j < 4; j++) begin
                in_v[j] = 12'($urandom);
                wa[j]   = 5'($urandom);
                wb[j]   = 5'($urandom);
            end
            if (t % 4 == 0) begin
                for (int j = 0; j < 4; j++) in_v[j] = 12'($urandom_range(0, 300));
            end
            run_txn($sformatf("rand%0d", t), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
